// File: rtl/pov_pkg.sv
// pov_pkg: key op and state encodings plus default character codes shared across the POV path
package pov_pkg;
   typedef enum logic [2:0] {
      KEY_ADD      = 3'd0,
      KEY_DELETE   = 3'd1,
      KEY_MODIFIER = 3'd2,
      KEY_ENTER    = 3'd3,
      KEY_CLEAR    = 3'd4
   } key_op_t;
   typedef enum logic [1:0] {S_LOAD, S_EDIT, S_COMMIT} state_t;
   localparam logic [7:0] POV_MOD_CHAR     = 8'h2C;
   localparam logic [7:0] POV_ENHE_LO_BASE = 8'h6E;
   localparam logic [7:0] POV_ENHE_LO      = 8'hF1;
   localparam logic [7:0] POV_ENHE_UP_BASE = 8'h4E;
   localparam logic [7:0] POV_ENHE_UP      = 8'hD1;
   localparam logic [7:0] POV_FILL_CHAR    = 8'h20;
endpackage

// File: rtl/pov_char_buffer.sv
// pov_char_buffer: MAX_LEN x CHAR_W message store, one write port, async reads masked against len
//   clk                      clock
//   we, wr_addr, wr_char     write port
//   len                      current message length (cells at or beyond it read as FILL_CHAR)
//   rd_addr -> rd_char       display/echo read
//   tail_char                buf[len-1], raw; only meaningful when len != 0
module pov_char_buffer
   import pov_pkg::*;
#(
   parameter int CHAR_W = 8,
   parameter int MAX_LEN = 32,
   parameter int LEN_W = $clog2(MAX_LEN + 1),
   parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(POV_FILL_CHAR)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [LEN_W-1:0]  wr_addr,
   input  logic [CHAR_W-1:0] wr_char,
   input  logic [LEN_W-1:0]  len,
   input  logic [LEN_W-1:0]  rd_addr,
   output logic [CHAR_W-1:0] rd_char,
   output logic [CHAR_W-1:0] tail_char
);
   localparam int AW = $clog2(MAX_LEN);
   logic [CHAR_W-1:0] mem [MAX_LEN];
   logic [LEN_W-1:0] tail_addr;
   assign tail_addr = len - 1'b1;
   always_ff @(posedge clk)
      if (we) mem[wr_addr[AW-1:0]] <= wr_char;
   // any address below len is below MAX_LEN, so the truncated index is exact where it matters
   assign rd_char = rd_addr < len ? mem[rd_addr[AW-1:0]] : FILL_CHAR;
   assign tail_char = mem[tail_addr[AW-1:0]];
endmodule

// File: rtl/pov_text_entry_ctrl.sv
// pov_text_entry_ctrl: keypad text-entry controller with edit buffer and commit handshake
//   clk, reset (sync, active-high)
//   key_valid/key_ready/key_op/key_char     key event handshake
//   rd_addr -> rd_char                      buffer read, FILL_CHAR at or beyond len
//   len, full, empty                        buffer status
//   changed, err                            one-cycle event result pulses
//   load                                    high while the buffer is being cleared
//   commit_valid/commit_ready/commit_len    finished message handshake
module pov_text_entry_ctrl
   import pov_pkg::*;
#(
   parameter int CHAR_W = 8,
   parameter int MAX_LEN = 32,
   parameter int LEN_W = $clog2(MAX_LEN + 1),
   parameter logic [CHAR_W-1:0] MOD_CHAR = CHAR_W'(POV_MOD_CHAR),
   parameter logic [CHAR_W-1:0] ENHE_LO_BASE = CHAR_W'(POV_ENHE_LO_BASE),
   parameter logic [CHAR_W-1:0] ENHE_LO = CHAR_W'(POV_ENHE_LO),
   parameter logic [CHAR_W-1:0] ENHE_UP_BASE = CHAR_W'(POV_ENHE_UP_BASE),
   parameter logic [CHAR_W-1:0] ENHE_UP = CHAR_W'(POV_ENHE_UP),
   parameter logic [CHAR_W-1:0] FILL_CHAR = CHAR_W'(POV_FILL_CHAR),
   parameter bit CLEAR_ON_COMMIT = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [2:0]        key_op,
   input  logic [CHAR_W-1:0] key_char,
   input  logic [LEN_W-1:0]  rd_addr,
   output logic [CHAR_W-1:0] rd_char,
   output logic [LEN_W-1:0]  len,
   output logic              full,
   output logic              empty,
   output logic              changed,
   output logic              err,
   output logic              load,
   output logic              commit_valid,
   input  logic              commit_ready,
   output logic [LEN_W-1:0]  commit_len
);
   state_t state;
   logic accept, is_mod, compose_lo, compose_up, compose, we;
   logic [CHAR_W-1:0] tail_char, wr_char;
   logic [LEN_W-1:0] wr_addr;
   assign full = len == LEN_W'(MAX_LEN);
   assign empty = len == '0;
   assign accept = key_valid & key_ready;
   assign is_mod = key_op == KEY_MODIFIER;
   assign compose_lo = !empty && tail_char == ENHE_LO_BASE;
   assign compose_up = !empty && tail_char == ENHE_UP_BASE;
   assign compose = is_mod & (compose_lo | compose_up);
   // append covers ADD and a modifier with nothing to compose; compose rewrites the last cell
   assign we = accept & (compose | (!full & (key_op == KEY_ADD | is_mod)));
   assign wr_addr = compose ? len - 1'b1 : len;
   assign wr_char = key_op == KEY_ADD ? key_char : compose_lo ? ENHE_LO : compose_up ? ENHE_UP : MOD_CHAR;
   pov_char_buffer #(
      .CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .FILL_CHAR(FILL_CHAR)
   ) u_buf (
      .clk(clk), .we(we), .wr_addr(wr_addr), .wr_char(wr_char), .len(len),
      .rd_addr(rd_addr), .rd_char(rd_char), .tail_char(tail_char)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_LOAD;
         len <= '0;
         key_ready <= 1'b0;
         changed <= 1'b0;
         err <= 1'b0;
         commit_valid <= 1'b0;
         commit_len <= '0;
         load <= 1'b1;
      end else begin
         changed <= 1'b0;
         err <= 1'b0;
         case (state)
            S_LOAD: begin
               len <= '0;
               load <= 1'b0;
               key_ready <= 1'b1;
               state <= S_EDIT;
            end
            S_EDIT: if (accept) case (key_op)
               KEY_ADD, KEY_MODIFIER: begin
                  if (compose) changed <= 1'b1;
                  else if (full) err <= 1'b1;
                  else begin
                     len <= len + 1'b1;
                     changed <= 1'b1;
                  end
               end
               KEY_DELETE: begin
                  if (empty) err <= 1'b1;
                  else begin
                     len <= len - 1'b1;
                     changed <= 1'b1;
                  end
               end
               KEY_ENTER: begin
                  if (empty) err <= 1'b1;
                  else begin
                     commit_len <= len;
                     commit_valid <= 1'b1;
                     key_ready <= 1'b0;
                     state <= S_COMMIT;
                  end
               end
               KEY_CLEAR: begin
                  changed <= !empty;
                  len <= '0;
                  load <= 1'b1;
                  key_ready <= 1'b0;
                  state <= S_LOAD;
               end
               default: err <= 1'b1;
            endcase
            S_COMMIT: if (commit_ready) begin
               commit_valid <= 1'b0;
               if (CLEAR_ON_COMMIT) begin
                  changed <= 1'b1;
                  len <= '0;
                  load <= 1'b1;
                  state <= S_LOAD;
               end else begin
                  key_ready <= 1'b1;
                  state <= S_EDIT;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end
endmodule
